// File: rtl/sha3_pkg.sv
// ---------------------------------------------------------------------------
// sha3_pkg
// Shared definitions for the multi-rate SHA-3 / Keccak input padder:
//   - digest mode encoding (mode port of sha3_padder_mr)
//   - padder state encoding
//   - rate in bits per mode
//   - padding byte for both domain settings
//   - words-per-block helper for a given mode and word width
// Configuration macro: SHA3_DOMAIN_EN
//   defined   -> PAD_BYTE = 0x06 (FIPS-202 SHA-3 domain separation)
//   undefined -> PAD_BYTE = 0x01 (original Keccak padding)
// ---------------------------------------------------------------------------
package sha3_pkg;

    typedef enum logic [1:0] {
        MODE_224 = 2'd0,
        MODE_256 = 2'd1,
        MODE_384 = 2'd2,
        MODE_512 = 2'd3
    } sha3_mode_e;

    typedef enum logic [1:0] {
        ST_FILL = 2'd0,
        ST_FULL = 2'd1,
        ST_DONE = 2'd2
    } pad_state_e;

    localparam int RATE_224 = 1152;
    localparam int RATE_256 = 1088;
    localparam int RATE_384 = 832;
    localparam int RATE_512 = 576;

    localparam logic [7:0] PAD_KECCAK = 8'h01;
    localparam logic [7:0] PAD_SHA3   = 8'h06;

`ifdef SHA3_DOMAIN_EN
    localparam logic [7:0] PAD_BYTE = PAD_SHA3;
`else
    localparam logic [7:0] PAD_BYTE = PAD_KECCAK;
`endif

    // Marker ORed into the final byte of the last padded block.
    localparam logic [7:0] PAD_END = 8'h80;

    function automatic int rate_bits(input sha3_mode_e m);
        case (m)
            MODE_224: return RATE_224;
            MODE_256: return RATE_256;
            MODE_384: return RATE_384;
            MODE_512: return RATE_512;
            default:  return RATE_512;
        endcase
    endfunction

    function automatic int words_per_block(input sha3_mode_e m, input int w);
        return rate_bits(m) / w;
    endfunction

endpackage

// File: rtl/sha3_pad_word.sv
// ---------------------------------------------------------------------------
// sha3_pad_word
// Combinational masking/padding of one message word (big-endian bytes,
// byte 0 in the top 8 bits).
//   in       : raw message word
//   byte_num : number of valid bytes when is_last=1
//   is_last  : word ends the message
//   word     : in unchanged for non-last words; otherwise the first
//              byte_num bytes of in, then PAD_BYTE, then zero bytes
// The final-block 0x80 marker is not applied here; the padder adds it at the
// end of the rate, which may or may not be inside this word.
// Configuration macro (via sha3_pkg): SHA3_DOMAIN_EN selects PAD_BYTE.
// ---------------------------------------------------------------------------
module sha3_pad_word
    import sha3_pkg::*;
#(
    parameter int W = 32
) (
    input  logic [W-1:0]            in,
    input  logic [$clog2(W/8)-1:0]  byte_num,
    input  logic                    is_last,
    output logic [W-1:0]            word
);

    // Byte-wise select between data, pad byte and zero for the last word.
    always_comb begin
        word = in;
        if (is_last) begin
            for (int b = 0; b < W / 8; b++) begin
                if (b < int'(byte_num)) begin
                    word[W-1-8*b -: 8] = in[W-1-8*b -: 8];
                end else if (b == int'(byte_num)) begin
                    word[W-1-8*b -: 8] = PAD_BYTE;
                end else begin
                    word[W-1-8*b -: 8] = 8'h00;
                end
            end
        end else begin
            word = in;
        end
    end

endmodule

// File: rtl/sha3_padder_mr.sv
// ---------------------------------------------------------------------------
// sha3_padder_mr
// Multi-rate Keccak/SHA-3 input padder. Packs W-bit big-endian message words
// into rate-sized blocks, applies multi-rate padding (PAD ... 0x80) and hands
// each block to the permutation core through out_ready/f_ack.
// Parameters:
//   W        : input word width, 32 or 64
//   RATE_MAX : width of out, at least the largest rate in use
// Ports:
//   clk, reset   : clock, asynchronous active-high reset
//   mode         : 0=224 (1152), 1=256 (1088), 2=384 (832), 3=512 (576);
//                  latched on the first accepted word after reset
//   in, in_ready : message word and its valid
//   is_last      : word ends the message
//   byte_num     : valid bytes in the last word (0..W/8-1)
//   buffer_full  : block held, no word accepted
//   out          : padded block, word k at out[RATE_MAX-1-k*W -: W]
//   out_ready    : out holds a complete block
//   out_last     : block on out is the final one of the message
//   f_ack        : core consumed out (only honoured while a block is held)
//   done         : final block acknowledged; all inputs ignored until reset
// Configuration macro: SHA3_DOMAIN_EN (selects PAD = 0x06 instead of 0x01).
// ---------------------------------------------------------------------------
module sha3_padder_mr
    import sha3_pkg::*;
#(
    parameter int W        = 32,
    parameter int RATE_MAX = 1152
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [1:0]              mode,
    input  logic [W-1:0]            in,
    input  logic                    in_ready,
    input  logic                    is_last,
    input  logic [$clog2(W/8)-1:0]  byte_num,
    output logic                    buffer_full,
    output logic [RATE_MAX-1:0]     out,
    output logic                    out_ready,
    output logic                    out_last,
    input  logic                    f_ack,
    output logic                    done
);

    localparam int SLOTS = RATE_MAX / W;
    localparam int CNT_W = $clog2(SLOTS + 1);
    localparam logic [RATE_MAX-1:0] END_MARK = {{(RATE_MAX-8){1'b0}}, PAD_END};

    pad_state_e            state_r, state_s;
    logic [CNT_W-1:0]      cnt_r, cnt_s;
    sha3_mode_e            mode_r, mode_s;
    logic                  started_r, started_s;
    logic [RATE_MAX-1:0]   buf_r, buf_s;
    logic                  out_last_r, out_last_s;
    logic                  done_r, done_s;
    logic                  full_r;

    sha3_mode_e            mode_eff_s;
    int                    n_s;
    logic [W-1:0]          pad_word_s;

    sha3_pad_word #(.W(W)) u_pad_word (
        .in       (in),
        .byte_num (byte_num),
        .is_last  (is_last),
        .word     (pad_word_s)
    );

    // Block geometry: the live mode pin is used only until the first word
    // of the message has latched it.
    always_comb begin
        mode_eff_s = started_r ? mode_r : sha3_mode_e'(mode);
        n_s        = words_per_block(mode_eff_s, W);
    end

    // Next-state, buffer update and flag computation.
    always_comb begin
        state_s    = state_r;
        cnt_s      = cnt_r;
        buf_s      = buf_r;
        mode_s     = mode_r;
        started_s  = started_r;
        out_last_s = out_last_r;
        done_s     = done_r;
        case (state_r)
            ST_FILL: begin
                if (in_ready) begin
                    // Slot cnt is still zero, so ORing the shifted word writes it.
                    buf_s = buf_r | ({pad_word_s, {(RATE_MAX-W){1'b0}}} >> (int'(cnt_r) * W));
                    cnt_s = cnt_r + CNT_W'(1);
                    if (!started_r) begin
                        mode_s    = sha3_mode_e'(mode);
                        started_s = 1'b1;
                    end else begin
                        mode_s    = mode_r;
                    end
                    if (is_last) begin
                        // 0x80 goes into the last byte of the rate, which can
                        // coincide with the pad byte just written.
                        buf_s      = buf_s | (END_MARK << (RATE_MAX - n_s * W));
                        state_s    = ST_FULL;
                        out_last_s = 1'b1;
                    end else if (int'(cnt_r) + 1 == n_s) begin
                        state_s    = ST_FULL;
                        out_last_s = 1'b0;
                    end else begin
                        state_s    = ST_FILL;
                    end
                end else begin
                    state_s = ST_FILL;
                end
            end
            ST_FULL: begin
                if (f_ack) begin
                    buf_s      = '0;
                    cnt_s      = '0;
                    out_last_s = 1'b0;
                    if (out_last_r) begin
                        state_s = ST_DONE;
                        done_s  = 1'b1;
                    end else begin
                        state_s = ST_FILL;
                    end
                end else begin
                    state_s = ST_FULL;
                end
            end
            ST_DONE: begin
                state_s = ST_DONE;
            end
            default: begin
                state_s = ST_FILL;
                cnt_s   = '0;
                buf_s   = '0;
            end
        endcase
    end

    // State and output registers; reset discards any partial or held block.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= ST_FILL;
            cnt_r      <= '0;
            mode_r     <= MODE_224;
            started_r  <= 1'b0;
            buf_r      <= '0;
            out_last_r <= 1'b0;
            done_r     <= 1'b0;
            full_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            cnt_r      <= cnt_s;
            mode_r     <= mode_s;
            started_r  <= started_s;
            buf_r      <= buf_s;
            out_last_r <= out_last_s;
            done_r     <= done_s;
            full_r     <= (state_s == ST_FULL);
        end
    end

    assign out         = buf_r;
    assign out_ready   = full_r;
    assign buffer_full = full_r;
    assign out_last    = out_last_r;
    assign done        = done_r;

endmodule

// File: tb/tb_sha3_padder_mr.sv
// ---------------------------------------------------------------------------
// tb_sha3_padder_mr
// Self-checking bench for sha3_padder_mr. A W=32 instance is exercised with
// directed and random messages checked against a byte-level padding model;
// a W=64 instance covers the 64-bit fill and asynchronous reset while FULL.
// Honours SHA3_DOMAIN_EN for the expected pad byte.
// ---------------------------------------------------------------------------
module tb_sha3_padder_mr;

`ifdef SHA3_DOMAIN_EN
    localparam logic [7:0] PAD = 8'h06;
`else
    localparam logic [7:0] PAD = 8'h01;
`endif

    logic          clk;
    logic          reset;

    logic [1:0]    mode32, mode64;
    logic [31:0]   in32;
    logic [63:0]   in64;
    logic          in_ready32, in_ready64, is_last32, is_last64;
    logic [1:0]    bn32;
    logic [2:0]    bn64;
    logic          f_ack32, f_ack64;
    logic          bf32, bf64, ordy32, ordy64, olast32, olast64, done32, done64;
    logic [1151:0] out32, out64;

    logic [7:0]    msg_q[$];
    logic [1151:0] last_blk;
    logic [63:0]   wd [18];
    int            n_checks = 0;
    int            n_errors = 0;

    sha3_padder_mr #(.W(32), .RATE_MAX(1152)) u_dut32 (
        .clk(clk), .reset(reset), .mode(mode32), .in(in32), .in_ready(in_ready32),
        .is_last(is_last32), .byte_num(bn32), .buffer_full(bf32), .out(out32),
        .out_ready(ordy32), .out_last(olast32), .f_ack(f_ack32), .done(done32)
    );

    sha3_padder_mr #(.W(64), .RATE_MAX(1152)) u_dut64 (
        .clk(clk), .reset(reset), .mode(mode64), .in(in64), .in_ready(in_ready64),
        .is_last(is_last64), .byte_num(bn64), .buffer_full(bf64), .out(out64),
        .out_ready(ordy64), .out_last(olast64), .f_ack(f_ack64), .done(done64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int rate_bytes(input logic [1:0] m);
        case (m)
            2'd0:    return 144;
            2'd1:    return 136;
            2'd2:    return 104;
            default: return 72;
        endcase
    endfunction

    // Reference: message bytes, then PAD, zeros up to a rate multiple,
    // 0x80 ORed into the very last byte; block blk of that padded string.
    function automatic logic [1151:0] exp_block(input int blk, input int rb, input int len);
        logic [1151:0] v;
        logic [7:0]    b;
        int            total;
        int            idx;
        v     = '0;
        total = (len / rb + 1) * rb;
        for (int j = 0; j < rb; j++) begin
            idx = blk * rb + j;
            if (idx < len)       b = msg_q[idx];
            else if (idx == len) b = PAD;
            else                 b = 8'h00;
            if (idx == total - 1) b = b | 8'h80;
            v[1151-8*j -: 8] = b;
        end
        return v;
    endfunction

    task automatic check_block32(input string tag, input logic [1151:0] exp);
        for (int k = 0; k < 36; k++) begin
            check_eq($sformatf("%s slot%0d", tag, k), 64'(out32[1151-32*k -: 32]), 64'(exp[1151-32*k -: 32]));
        end
    endtask

    task automatic do_reset();
        in_ready32 = 1'b0; in_ready64 = 1'b0; f_ack32 = 1'b0; f_ack64 = 1'b0;
        is_last32  = 1'b0; is_last64  = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    // Feed msg_q to the W=32 instance in mode m and check every block.
    task automatic run_msg(input logic [1:0] m);
        int            len, rb, nw, nfull, blk, wib;
        logic [31:0]   w;
        logic [1151:0] exp;
        logic          last;
        len = msg_q.size(); rb = rate_bytes(m); nw = rb / 4; nfull = len / 4;
        blk = 0; wib = 0;
        for (int wi = 0; wi <= nfull; wi++) begin
            last = (wi == nfull);
            w = $urandom;
            for (int b = 0; b < 4; b++) begin
                if (wi * 4 + b < len) w[31-8*b -: 8] = msg_q[wi*4+b];
            end
            if ($urandom_range(0, 3) == 0) begin
                in_ready32 = 1'b0; in32 = $urandom; is_last32 = 1'($urandom);
                mode32 = 2'($urandom); f_ack32 = 1'($urandom);
                @(negedge clk);
                f_ack32 = 1'b0;
                check_eq("idle rdy", 64'(ordy32), 64'(0));
            end
            in32 = w; in_ready32 = 1'b1; is_last32 = last;
            bn32 = last ? 2'(len % 4) : 2'($urandom);
            mode32 = (wi == 0) ? m : 2'($urandom);
            @(negedge clk);
            in_ready32 = 1'b0;
            wib++;
            if (wib == nw || last) begin
                exp = exp_block(blk, rb, len);
                check_eq("out_ready", 64'(ordy32), 64'(1));
                check_eq("buffer_full", 64'(bf32), 64'(1));
                check_eq("out_last", 64'(olast32), 64'(last));
                check_block32($sformatf("blk%0d", blk), exp);
                last_blk = out32;
                // Host keeps offering a word while the block is held.
                in32 = 32'h999; in_ready32 = 1'b1; is_last32 = 1'b0;
                repeat ($urandom_range(0, 2)) begin
                    @(negedge clk);
                    check_eq("hold rdy", 64'(ordy32), 64'(1));
                end
                f_ack32 = 1'b1;
                @(negedge clk);
                f_ack32 = 1'b0; in_ready32 = 1'b0;
                check_eq("ack rdy", 64'(ordy32), 64'(0));
                check_eq("ack full", 64'(bf32), 64'(0));
                check_eq("ack clr", 64'(out32 != '0), 64'(0));
                blk++; wib = 0;
                if (last) begin
                    check_eq("done", 64'(done32), 64'(1));
                    repeat (5) begin
                        in32 = $urandom; in_ready32 = 1'b1; is_last32 = 1'($urandom);
                        f_ack32 = 1'($urandom);
                        @(negedge clk);
                        check_eq("done full", 64'(bf32), 64'(0));
                        check_eq("done rdy", 64'(ordy32), 64'(0));
                        check_eq("done hold", 64'(done32), 64'(1));
                    end
                    in_ready32 = 1'b0; f_ack32 = 1'b0;
                end
            end else begin
                check_eq("fill rdy", 64'(ordy32), 64'(0));
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        string s;
        int    m, len, rb;
        mode32 = 2'd0; mode64 = 2'd0; in32 = '0; in64 = '0; bn32 = '0; bn64 = '0;
        in_ready32 = 1'b0; in_ready64 = 1'b0; is_last32 = 1'b0; is_last64 = 1'b0;
        f_ack32 = 1'b0; f_ack64 = 1'b0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_eq("rst rdy", 64'(ordy32), 64'(0));
        check_eq("rst full", 64'(bf32), 64'(0));
        check_eq("rst last", 64'(olast32), 64'(0));
        check_eq("rst done", 64'(done32), 64'(0));
        check_eq("rst out", 64'(out32 != '0), 64'(0));
        check_eq("rst64 rdy", 64'(ordy64), 64'(0));

        // Pangram, 43 bytes, mode 512.
        s = "The quick brown fox jumps over the lazy dog ";
        msg_q.delete();
        for (int i = 0; i < 43; i++) msg_q.push_back(s[i]);
        run_msg(2'd3);
        check_eq("fox slot0", 64'(last_blk[1151-32*0 -: 32]), 64'(32'h54686520));
        check_eq("fox slot10", 64'(last_blk[1151-32*10 -: 32]), 64'({24'h646f67, PAD}));
        check_eq("fox slot17", 64'(last_blk[1151-32*17 -: 32]), 64'(32'h00000080));
        do_reset();

        // Exactly one rate of data: extra all-padding block.
        msg_q.delete();
        for (int i = 0; i < 72; i++) msg_q.push_back(8'($urandom));
        run_msg(2'd3);
        check_eq("rate slot0", 64'(last_blk[1151 -: 32]), 64'({PAD, 24'h0}));
        check_eq("rate slot17", 64'(last_blk[1151-32*17 -: 32]), 64'(32'h00000080));
        do_reset();

        // Pad byte lands in the final byte of the block.
        msg_q.delete();
        for (int i = 0; i < 68; i++) msg_q.push_back(8'($urandom));
        msg_q.push_back(8'h78); msg_q.push_back(8'h56); msg_q.push_back(8'h34);
        run_msg(2'd3);
        check_eq("edge slot17", 64'(last_blk[1151-32*17 -: 32]), 64'({24'h785634, PAD | 8'h80}));
        do_reset();

        // Empty message.
        msg_q.delete();
        run_msg(2'd3);
        check_eq("empty slot0", 64'(last_blk[1151 -: 32]), 64'({PAD, 24'h0}));
        check_eq("empty slot17", 64'(last_blk[1151-32*17 -: 32]), 64'(32'h00000080));
        do_reset();

        // Random messages in random modes.
        repeat (12) begin
            m  = $urandom_range(0, 3);
            rb = rate_bytes(2'(m));
            if ($urandom_range(0, 3) == 0) len = rb * $urandom_range(1, 2);
            else                           len = $urandom_range(0, 320);
            msg_q.delete();
            for (int i = 0; i < len; i++) msg_q.push_back(8'($urandom));
            run_msg(2'(m));
            do_reset();
        end

        // W=64, mode 224: 18 words fill one block; reset while FULL.
        mode64 = 2'd0;
        for (int k = 0; k < 18; k++) begin
            wd[k] = {$urandom, $urandom};
            in64 = wd[k]; in_ready64 = 1'b1; is_last64 = 1'b0;
            @(negedge clk);
            check_eq($sformatf("w64 full%0d", k), 64'(bf64), 64'(k == 17));
        end
        in_ready64 = 1'b0;
        check_eq("w64 rdy", 64'(ordy64), 64'(1));
        check_eq("w64 last", 64'(olast64), 64'(0));
        for (int k = 0; k < 18; k++) begin
            check_eq($sformatf("w64 slot%0d", k), out64[1151-64*k -: 64], wd[k]);
        end
        #2;
        reset = 1'b1;
        #1;
        check_eq("w64 rst rdy", 64'(ordy64), 64'(0));
        check_eq("w64 rst full", 64'(bf64), 64'(0));
        check_eq("w64 rst out", 64'(out64 != '0), 64'(0));
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
